riscv_wb_arbiter: RTL

Arbitrates the single GPR write port between the execute unit (`riscv_exec`) and the load/store unit (`riscv_lsu`). It replaces the ad-hoc combinational writeback mux with a registered, fixed-priority arbiter. The arbiter has a one-entry skid buffer for displaced exec results, a starvation guard, and a pending-write indication for decode. It sits between the exec/LSU writeback outputs and `riscv_GPRs_write`.

---
 rtl/riscv_wb_pkg.sv | 21 ++
 rtl/riscv_wb_skid.sv | 32 +++
 rtl/riscv_wb_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared types for the GPR writeback arbiter.
// FSM encoding, write-source select and datapath widths.
package riscv_wb_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int XLEN        = 32;
  localparam int WB_STARVE_W = 3;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_HELD = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_EXEC = 2'd1,
    SEL_LSU  = 2'd2,
    SEL_SKID = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/riscv_wb_skid.sv
// One-entry park register for an exec result displaced by a load.
// Load captures rd/data and sets valid; clear drops valid.
module riscv_wb_skid
  import riscv_wb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [REG_IDX_W-1:0] rd_i,
  input  logic [XLEN-1:0]      data_i,
  output logic                 valid_o,
  output logic [REG_IDX_W-1:0] rd_o,
  output logic [XLEN-1:0]      data_o
);

  // Entry register; rd/data only change on load so bypass sees a stable value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      rd_o    <= '0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      rd_o    <= rd_i;
      data_o  <= data_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Registered fixed-priority GPR write arbiter (LSU over exec) with skid.
// Optional operand forwarding enabled by defining RISCV_WB_BYPASS_EN.
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 exec_valid_i,
  input  logic [REG_IDX_W-1:0] exec_rd_i,
  input  logic [XLEN-1:0]      exec_value_i,
  output logic                 exec_accept_o,
  input  logic                 lsu_valid_i,
  input  logic [REG_IDX_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]      lsu_value_i,
  output logic                 lsu_accept_o,
  output logic                 reg_write_en_o,
  output logic [REG_IDX_W-1:0] reg_write_dest_o,
  output logic [XLEN-1:0]      reg_write_data_o,
  output logic                 pending_valid_o,
  output logic [REG_IDX_W-1:0] pending_rd_o,
  input  logic [REG_IDX_W-1:0] ra_idx_i,
  input  logic [REG_IDX_W-1:0] rb_idx_i,
  input  logic [XLEN-1:0]      ra_value_i,
  input  logic [XLEN-1:0]      rb_value_i,
  output logic [XLEN-1:0]      ra_value_o,
  output logic [XLEN-1:0]      rb_value_o
);

  localparam logic [WB_STARVE_W-1:0] STARVE_LIM =
    WB_STARVE_W'(STARVE_MAX);

  wb_state_e              state_q;
  logic [WB_STARVE_W-1:0] starve_cnt;
  wb_sel_e                sel;
  logic                   park;
  logic                   unpark;
  logic                   exec_live;
  logic                   lsu_live;
  logic [XLEN-1:0]        skid_data;

  assign exec_live = exec_valid_i && (exec_rd_i != '0);
  assign lsu_live  = lsu_valid_i && (lsu_rd_i != '0);

  // Pick the write source and handshakes; rd=0 requests are taken but dropped
  always_comb begin
    sel           = SEL_NONE;
    park          = 1'b0;
    unpark        = 1'b0;
    exec_accept_o = 1'b0;
    lsu_accept_o  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        WB_IDLE: begin
          exec_accept_o = 1'b1;
          lsu_accept_o  = lsu_valid_i;
          if (lsu_live) begin
            sel  = SEL_LSU;
            park = exec_live;
          end else if (exec_live) begin
            sel = SEL_EXEC;
          end
        end
        WB_HELD: begin
          lsu_accept_o = lsu_valid_i && (starve_cnt < STARVE_LIM);
          if (lsu_live && starve_cnt < STARVE_LIM) begin
            sel = SEL_LSU;
          end else begin
            sel    = SEL_SKID;
            unpark = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM plus registered write port; dest/data hold on idle cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= WB_IDLE;
      starve_cnt       <= '0;
      reg_write_en_o   <= 1'b0;
      reg_write_dest_o <= '0;
      reg_write_data_o <= '0;
    end else begin
      reg_write_en_o <= (sel != SEL_NONE);
      unique case (sel)
        SEL_EXEC: begin
          reg_write_dest_o <= exec_rd_i;
          reg_write_data_o <= exec_value_i;
        end
        SEL_LSU: begin
          reg_write_dest_o <= lsu_rd_i;
          reg_write_data_o <= lsu_value_i;
        end
        SEL_SKID: begin
          reg_write_dest_o <= pending_rd_o;
          reg_write_data_o <= skid_data;
        end
        default: ;
      endcase
      if (park) begin
        state_q    <= WB_HELD;
        starve_cnt <= '0;
      end else if (unpark) begin
        state_q <= WB_IDLE;
      end else if (state_q == WB_HELD && sel == SEL_LSU &&
                   starve_cnt != '1) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  riscv_wb_skid u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (park),
    .clear_i (unpark),
    .rd_i    (exec_rd_i),
    .data_i  (exec_value_i),
    .valid_o (pending_valid_o),
    .rd_o    (pending_rd_o),
    .data_o  (skid_data)
  );

`ifdef RISCV_WB_BYPASS_EN
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_IDX_W-1:0] idx,
    input logic [XLEN-1:0]      rf
  );
    if (idx == '0)
      return rf;
    else if (pending_valid_o && pending_rd_o == idx)
      return skid_data;
    else if (reg_write_en_o && reg_write_dest_o == idx)
      return reg_write_data_o;
    else
      return rf;
  endfunction

  // Forward younger in-flight values; skid beats the write port
  always_comb begin
    ra_value_o = fwd(ra_idx_i, ra_value_i);
    rb_value_o = fwd(rb_idx_i, rb_value_i);
  end
`else
  logic unused_idx;
  assign unused_idx = ^{ra_idx_i, rb_idx_i};

  // Forwarding disabled; decode stalls on pending_* instead
  always_comb begin
    ra_value_o = ra_value_i;
    rb_value_o = rb_value_i;
  end
`endif

endmodule
